// File: rtl/lsu_pkg.sv
// lsu_pkg: shared size encodings and FSM state type for the load/store SRAM front-end
package lsu_pkg;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane enables, store replication, load extraction/extension and alignment check
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_dout,
  output logic [3:0]  be,
  output logic [31:0] di,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);
  logic [31:0] sh;
  // pure lane steering; the selected lane is shifted down before extension
  always_comb begin
    sh = mem_dout >> (size == SZ_BYTE ? {addr, 3'b000} : {addr[1], 4'b0000});
    misaligned = (size == 2'd3) || (size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr != 2'b00);
    be = size == SZ_BYTE ? 4'b0001 << addr : size == SZ_HALF ? (addr[1] ? 4'b1100 : 4'b0011) : size == SZ_WORD ? 4'b1111 : 4'b0000;
    di = size == SZ_BYTE ? {4{wdata[7:0]}} : size == SZ_HALF ? {2{wdata[15:0]}} : wdata;
    rdata_ext = size == SZ_BYTE ? {{24{~uns & sh[7]}}, sh[7:0]} : size == SZ_HALF ? {{16{~uns & sh[15]}}, sh[15:0]} : mem_dout;
  end
endmodule

// File: rtl/lsu_sram_ctrl.sv
// lsu_sram_ctrl: single-request load/store FSM driving a single-port SRAM with registered pin outputs
module lsu_sram_ctrl
  import lsu_pkg::*;
#(
  parameter int AWIDTH = 12
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              MEM_CSN,
  output logic              MEM_WEN,
  output logic [AWIDTH-1:0] MEM_ADDR,
  output logic [3:0]        MEM_BE,
  output logic [31:0]       MEM_DI,
  input  logic [31:0]       MEM_DOUT
);
  state_t      state;
  logic        we_q, uns_q, idle, misaligned, unused_addr;
  logic [1:0]  size_q, lane_q;
  logic [3:0]  be;
  logic [31:0] di, rdata_ext;
  assign idle = state == IDLE;
  assign req_ready = idle;
  assign resp_valid = state == RESP;
  assign unused_addr = ^req_addr[31:AWIDTH+2];
  // in IDLE the lanes decode the incoming request; afterwards they decode the latched one for the load
  lsu_lane_align u_align (
    .size      (idle ? req_size : size_q),
    .addr      (idle ? req_addr[1:0] : lane_q),
    .uns       (uns_q),
    .wdata     (req_wdata),
    .mem_dout  (MEM_DOUT),
    .be        (be),
    .di        (di),
    .rdata_ext (rdata_ext),
    .misaligned(misaligned)
  );
  // FSM with SRAM strobes as flops so CSN/WEN are glitch-free and settle right after the posedge
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'd0;
      lane_q     <= 2'd0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      MEM_CSN    <= 1'b1;
      MEM_WEN    <= 1'b1;
      MEM_BE     <= 4'b0000;
      MEM_ADDR   <= '0;
      MEM_DI     <= '0;
    end else
      case (state)
        IDLE: if (req_valid) begin
          we_q   <= req_we;
          uns_q  <= req_unsigned;
          size_q <= req_size;
          lane_q <= req_addr[1:0];
          if (misaligned) begin
            resp_err   <= 1'b1;
            resp_rdata <= '0;
            state      <= RESP;
          end else begin
            MEM_CSN  <= 1'b0;
            MEM_WEN  <= ~req_we;
            MEM_BE   <= be;
            MEM_ADDR <= req_addr[AWIDTH+1:2];
            MEM_DI   <= di;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          resp_rdata <= we_q ? '0 : rdata_ext;
          MEM_CSN    <= 1'b1;
          MEM_WEN    <= 1'b1;
          MEM_BE     <= 4'b0000;
          state      <= RESP;
        end
        RESP: if (resp_ready) begin
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_lsu_sram_ctrl.sv
// tb_lsu_sram_ctrl: directed stimulus with a response scoreboard and a behavioural SRAM
module tb_lsu_sram_ctrl;
  logic        CLK = 1'b0, RSTn, req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata, resp_rdata, MEM_DI, MEM_DOUT;
  logic        resp_valid, resp_ready, resp_err, MEM_CSN, MEM_WEN;
  logic [11:0] MEM_ADDR;
  logic [3:0]  MEM_BE;
  logic [31:0] mem [0:4095];
  logic [32:0] exp_q [$];
  logic [32:0] mon_e;
  int checks = 0, errors = 0, csn_cnt = 0;
  logic [31:0] hold_rd;

  lsu_sram_ctrl #(.AWIDTH(12)) dut (
    .CLK(CLK), .RSTn(RSTn), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .MEM_CSN(MEM_CSN), .MEM_WEN(MEM_WEN), .MEM_ADDR(MEM_ADDR), .MEM_BE(MEM_BE), .MEM_DI(MEM_DI),
    .MEM_DOUT(MEM_DOUT)
  );

  always #5 CLK = ~CLK;
  assign MEM_DOUT = mem[MEM_ADDR];

  always @(negedge CLK) begin
    if (!MEM_CSN) csn_cnt++;
    if (!MEM_CSN && !MEM_WEN)
      for (int b = 0; b < 4; b++)
        if (MEM_BE[b]) mem[MEM_ADDR][8*b +: 8] = MEM_DI[8*b +: 8];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  always @(negedge CLK)
    if (RSTn && resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got err=%b rdata=%h, required no response", resp_err, resp_rdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_err", {31'd0, resp_err}, {31'd0, mon_e[32]});
        chk("resp_rdata", resp_rdata, mon_e[31:0]);
      end
    end

  task automatic xfer(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                      input logic [31:0] wd, input logic err, input logic [31:0] rd,
                      input logic [3:0] be, input logic [31:0] di);
    int c0;
    c0 = csn_cnt;
    exp_q.push_back({err, rd});
    req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    if (err) begin
      chk("err_latency", {31'd0, resp_valid}, 32'd1);
      chk("err_csn", {31'd0, MEM_CSN}, 32'd1);
      chk("err_be", {28'd0, MEM_BE}, 32'd0);
    end else begin
      chk("acc_valid", {31'd0, resp_valid}, 32'd0);
      chk("acc_csn", {31'd0, MEM_CSN}, 32'd0);
      chk("acc_wen", {31'd0, MEM_WEN}, {31'd0, ~we});
      chk("acc_addr", {20'd0, MEM_ADDR}, {20'd0, a[13:2]});
      chk("acc_be", {28'd0, MEM_BE}, {28'd0, be});
      if (we) chk("acc_di", MEM_DI, di);
      @(posedge CLK); #1;
      chk("latency", {31'd0, resp_valid}, 32'd1);
      chk("post_csn", {31'd0, MEM_CSN}, 32'd1);
    end
    @(posedge CLK); #1;
    chk("done_valid", {31'd0, resp_valid}, 32'd0);
    chk("csn_pulses", csn_cnt - c0, err ? 32'd0 : 32'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_csn", {31'd0, MEM_CSN}, 32'd1);
    chk("rst_wen", {31'd0, MEM_WEN}, 32'd1);
    chk("rst_be", {28'd0, MEM_BE}, 32'd0);
    chk("rst_addr", {20'd0, MEM_ADDR}, 32'd0);
    chk("rst_di", MEM_DI, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'd0;
    RSTn = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk_reset_vals();
    RSTn = 1'b1;
    @(posedge CLK); #1;
    xfer(1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0, 4'b1111, 32'hDEADBEEF);
    chk("mem_word_store", mem[4], 32'hDEADBEEF);
    mem[4] = 32'h80112233;
    xfer(0, 0, 0, 32'h13, 32'h0, 0, 32'hFFFFFF80, 4'b1000, 32'h0);
    xfer(0, 0, 1, 32'h13, 32'h0, 0, 32'h00000080, 4'b1000, 32'h0);
    xfer(0, 1, 0, 32'h10, 32'h0, 0, 32'h00002233, 4'b0011, 32'h0);
    xfer(0, 0, 0, 32'h11, 32'h0, 0, 32'h00000022, 4'b0010, 32'h0);
    xfer(0, 1, 0, 32'h12, 32'h0, 0, 32'hFFFF8011, 4'b1100, 32'h0);
    xfer(1, 1, 0, 32'h12, 32'h0000ABCD, 0, 32'h0, 4'b1100, 32'hABCDABCD);
    chk("mem_half_store", mem[4], 32'hABCD2233);
    xfer(0, 2, 0, 32'h10, 32'h0, 0, 32'hABCD2233, 4'b1111, 32'h0);
    xfer(1, 0, 0, 32'h21, 32'h0000005A, 0, 32'h0, 4'b0010, 32'h5A5A5A5A);
    chk("mem_byte_store", mem[8], 32'h00005A00);
    xfer(0, 2, 0, 32'hFFFFC010, 32'h0, 0, 32'hABCD2233, 4'b1111, 32'h0);
    xfer(0, 2, 0, 32'h16, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
    xfer(0, 3, 0, 32'h10, 32'h0, 1, 32'h0, 4'b0000, 32'h0);
    xfer(1, 1, 0, 32'h11, 32'h0000FFFF, 1, 32'h0, 4'b0000, 32'h0);
    chk("mem_err_untouched", mem[4], 32'hABCD2233);
    chk("addr_hold", {20'd0, MEM_ADDR}, 32'd4);
    // backpressure with a held request
    resp_ready = 1'b0;
    exp_q.push_back({1'b0, 32'hABCD2233});
    exp_q.push_back({1'b0, 32'hABCD2233});
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    chk("bp_valid", {31'd0, resp_valid}, 32'd1);
    hold_rd = resp_rdata;
    begin
      int c0;
      c0 = csn_cnt;
      for (int i = 0; i < 3; i++) begin
        @(posedge CLK); #1;
        chk("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
        chk("bp_hold_rdata", resp_rdata, 32'hABCD2233);
        chk("bp_stable", resp_rdata, hold_rd);
        chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
        chk("bp_no_csn", csn_cnt - c0, 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge CLK); #1;
      chk("bp_idle", {31'd0, req_ready}, 32'd1);
      chk("bp_no_csn_idle", csn_cnt - c0, 32'd0);
      @(posedge CLK); #1;
      req_valid = 1'b0;
      chk("bp_second_csn", {31'd0, MEM_CSN}, 32'd0);
      @(posedge CLK); #1;
      chk("bp_second_pulse", csn_cnt - c0, 32'd1);
      chk("bp_second_valid", {31'd0, resp_valid}, 32'd1);
      @(posedge CLK); #1;
    end
    // reset in the first half of a store access
    req_we = 1'b1; req_size = 2'd2; req_addr = 32'h10; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge CLK); #1;
    chk("abort_csn_low", {31'd0, MEM_CSN}, 32'd0);
    RSTn = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("abort_csn_high", {31'd0, MEM_CSN}, 32'd1);
    @(negedge CLK); #1;
    chk("abort_mem", mem[4], 32'hABCD2233);
    chk_reset_vals();
    @(posedge CLK); #1;
    RSTn = 1'b1;
    @(posedge CLK); #1;
    xfer(0, 2, 0, 32'h10, 32'h0, 0, 32'hABCD2233, 4'b1111, 32'h0);
    chk("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
